// File: rtl/lcisc_subtract_pkg.sv
// Shared lcisc subtract definitions: default widths, the immediate-or-address
// operand, the single-flag condition, the packed subtract request and the
// executor state enum.
package lcisc_subtract_pkg;

  localparam int unsigned LCISC_ADDR_W     = 8;
  localparam int unsigned LCISC_NUM_FLAGS  = 8;
  localparam int unsigned LCISC_FLAG_IDX_W = $clog2(LCISC_NUM_FLAGS);

  // Operand: immediate value, or register address in val[ADDR_W-1:0].
  typedef struct packed {
    logic        is_addr;
    logic [31:0] val;
  } ia_u32_t;

  // Condition: passes when disabled, else when flags[idx] == pol.
  typedef struct packed {
    logic                        en;
    logic [LCISC_FLAG_IDX_W-1:0] idx;
    logic                        pol;
  } cond_t;

  typedef struct packed {
    ia_u32_t                 op1;
    ia_u32_t                 op2;
    logic [LCISC_ADDR_W-1:0] dest;
    cond_t                   cond;
  } subtract_req_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_WB,
    ST_RSP
  } sub_state_e;

endpackage

// File: rtl/lcisc_cond_check.sv
// Combinational condition evaluator shared by lcisc executors.
// Ports:
//   cond  - condition {en, idx, pol}
//   flags - environment flag vector
//   pass  - 1 when the instruction may execute
module lcisc_cond_check
  import lcisc_subtract_pkg::*;
#(
  parameter int unsigned NUM_FLAGS = LCISC_NUM_FLAGS
) (
  input  cond_t                cond,
  input  logic [NUM_FLAGS-1:0] flags,
  output logic                 pass
);

  int unsigned idx;

  always_comb begin
    idx  = 32'(cond.idx);
    pass = 1'b1;
    if (cond.en) begin
      // Out-of-range flag indices never pass.
      if (idx < NUM_FLAGS) begin
        pass = (flags[cond.idx] == cond.pol);
      end else begin
        pass = 1'b0;
      end
    end
  end

endmodule

// File: rtl/subtract_exec_unit.sv
// Sequential executor for lcisc subtract instructions. Accepts one request,
// resolves address operands through a single register-file read port, writes
// A - B (mod 2^32) to dest when the condition holds, then presents a response.
// Ports:
//   clk, rst_n               - clock, async active-low reset
//   in_valid/in_ready/in_req - request handshake and packed subtract_req_t
//   flags                    - condition flags, sampled in RD_A only
//   rf_rd_en/addr/data       - register read port (data one cycle after en)
//   rf_wr_en/addr/data       - register write port (one-cycle strobe)
//   rsp_valid/rsp_ready      - response handshake
//   rsp_executed/borrow/zero - response status, held stable while valid
module subtract_exec_unit
  import lcisc_subtract_pkg::*;
#(
  parameter int unsigned ADDR_W    = LCISC_ADDR_W,
  parameter int unsigned NUM_FLAGS = LCISC_NUM_FLAGS
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [$bits(subtract_req_t)-1:0] in_req,
  input  logic [NUM_FLAGS-1:0]             flags,
  output logic                             rf_rd_en,
  output logic [ADDR_W-1:0]                rf_rd_addr,
  input  logic [31:0]                      rf_rd_data,
  output logic                             rf_wr_en,
  output logic [ADDR_W-1:0]                rf_wr_addr,
  output logic [31:0]                      rf_wr_data,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic                             rsp_executed,
  output logic                             rsp_borrow,
  output logic                             rsp_zero
);

  sub_state_e    state, state_nxt;
  subtract_req_t req_q;
  logic [31:0]   a_q;
  logic          exec_q, borrow_q, zero_q;
  logic          cond_pass;
  logic [31:0]   b_val;

  lcisc_cond_check #(.NUM_FLAGS(NUM_FLAGS)) u_cond (
    .cond  (req_q.cond),
    .flags (flags),
    .pass  (cond_pass)
  );

  // B is only consumed in WB, where rf_rd_data holds the op2 read.
  assign b_val = req_q.op2.is_addr ? rf_rd_data : req_q.op2.val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_q    <= '0;
      a_q      <= '0;
      exec_q   <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (in_valid) req_q <= subtract_req_t'(in_req);
        ST_RD_A: begin
          exec_q   <= cond_pass;
          borrow_q <= 1'b0;
          zero_q   <= 1'b0;
        end
        ST_RD_B: a_q <= req_q.op1.is_addr ? rf_rd_data : req_q.op1.val;
        ST_WB: begin
          borrow_q <= (a_q < b_val);
          zero_q   <= (a_q == b_val);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_RD_A;
      ST_RD_A: state_nxt = cond_pass ? ST_RD_B : ST_RSP;
      ST_RD_B: state_nxt = ST_WB;
      ST_WB:   state_nxt = ST_RSP;
      ST_RSP:  if (rsp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    case (state)
      ST_RD_A: begin
        if (cond_pass && req_q.op1.is_addr) begin
          rf_rd_en   = 1'b1;
          rf_rd_addr = req_q.op1.val[ADDR_W-1:0];
        end
      end
      ST_RD_B: begin
        if (req_q.op2.is_addr) begin
          rf_rd_en   = 1'b1;
          rf_rd_addr = req_q.op2.val[ADDR_W-1:0];
        end
      end
      ST_WB: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = req_q.dest[ADDR_W-1:0];
        rf_wr_data = a_q - b_val;
      end
      default: ;
    endcase
  end

  // in_ready stays low while reset is held.
  assign in_ready     = rst_n && (state == ST_IDLE);
  assign rsp_valid    = (state == ST_RSP);
  assign rsp_executed = rsp_valid && exec_q;
  assign rsp_borrow   = rsp_valid && borrow_q;
  assign rsp_zero     = rsp_valid && zero_q;

endmodule

// File: tb/tb_subtract_exec_unit.sv
// Self-checking bench for subtract_exec_unit: table-driven directed vectors,
// a reset-during-RD_B sequence and randomized requests against a reference model.
module tb_subtract_exec_unit;
  import lcisc_subtract_pkg::*;

  localparam int unsigned AW = LCISC_ADDR_W;
  localparam int unsigned NF = LCISC_NUM_FLAGS;

  logic                             clk = 1'b0;
  logic                             rst_n = 1'b0;
  logic                             in_valid = 1'b0;
  logic                             in_ready;
  logic [$bits(subtract_req_t)-1:0] in_req = '0;
  logic [NF-1:0]                    flags = '0;
  logic                             rf_rd_en;
  logic [AW-1:0]                    rf_rd_addr;
  logic [31:0]                      rf_rd_data;
  logic                             rf_wr_en;
  logic [AW-1:0]                    rf_wr_addr;
  logic [31:0]                      rf_wr_data;
  logic                             rsp_valid;
  logic                             rsp_ready = 1'b0;
  logic                             rsp_executed, rsp_borrow, rsp_zero;

  subtract_exec_unit #(.ADDR_W(AW), .NUM_FLAGS(NF)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_req       (in_req),
    .flags        (flags),
    .rf_rd_en     (rf_rd_en),
    .rf_rd_addr   (rf_rd_addr),
    .rf_rd_data   (rf_rd_data),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_wr_data   (rf_wr_data),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_executed (rsp_executed),
    .rsp_borrow   (rsp_borrow),
    .rsp_zero     (rsp_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      1:       return 32'h0;
      2:       return 32'h1;
      7:       return 32'h1234_5678;
      default: return 32'(i) * 32'h9E37_79B1;
    endcase
  endfunction

  // Register file seen by the DUT; read data is garbage when no read was issued.
  logic [31:0] rf_mem [256];
  logic        rf_load = 1'b1;
  always @(posedge clk) begin
    if (rf_load) begin
      for (int i = 0; i < 256; i++) rf_mem[i] <= init_val(i);
      rf_rd_data <= 32'hDEAD_BEEF;
    end else begin
      rf_rd_data <= rf_rd_en ? rf_mem[rf_rd_addr] : 32'hDEAD_BEEF;
      if (rf_wr_en) rf_mem[rf_wr_addr] <= rf_wr_data;
    end
  end

  logic [31:0] model_rf [256];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic rd_en, input logic [AW-1:0] rd_addr,
                                     input logic wr_en, input logic [AW-1:0] wr_addr,
                                     input logic [31:0] wr_data, input logic rv, input logic ir);
    return {12'h0, rd_en, rd_addr, wr_en, wr_addr, wr_data, rv, ir};
  endfunction

  function automatic logic [63:0] snap();
    return {12'h0, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data, rsp_valid, in_ready};
  endfunction

  // Reference: instruction semantics in plain arithmetic.
  task automatic model_eval(input subtract_req_t r, input logic [NF-1:0] fl,
                            output logic ex, output logic [31:0] d,
                            output logic bo, output logic ze);
    longint unsigned a, b;
    int unsigned fi;
    a  = r.op1.is_addr ? longint'(model_rf[int'(r.op1.val % 256)]) : longint'(r.op1.val);
    b  = r.op2.is_addr ? longint'(model_rf[int'(r.op2.val % 256)]) : longint'(r.op2.val);
    fi = int'(r.cond.idx);
    ex = !r.cond.en || (fi < NF && fl[fi] == r.cond.pol);
    d  = '0; bo = 1'b0; ze = 1'b0;
    if (ex) begin
      d  = 32'((a + 64'h1_0000_0000 - b) % 64'h1_0000_0000);
      bo = a < b;
      ze = a == b;
    end
  endtask

  task automatic run_instr(input string name, input subtract_req_t r, input logic [NF-1:0] fl,
                           input int unsigned hold, input logic e_exec, input logic [31:0] e_data,
                           input logic e_borrow, input logic e_zero);
    int unsigned last;
    logic [63:0] exp;
    @(negedge clk);
    check($sformatf("%s:ready", name), 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_req = r; flags = fl;
    @(posedge clk); #1;
    in_valid = 1'b0; in_req = '0;
    last = e_exec ? 4 : 2;
    for (int unsigned c = 1; c <= last; c++) begin
      exp = mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
      if (e_exec) begin
        case (c)
          1: if (r.op1.is_addr) exp = mk(1'b1, r.op1.val[AW-1:0], 1'b0, '0, '0, 1'b0, 1'b0);
          2: if (r.op2.is_addr) exp = mk(1'b1, r.op2.val[AW-1:0], 1'b0, '0, '0, 1'b0, 1'b0);
          3: exp = mk(1'b0, '0, 1'b1, r.dest, e_data, 1'b0, 1'b0);
          default: exp = mk(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
        endcase
      end else if (c == 2) begin
        exp = mk(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0);
      end
      // RD_A has been left by cycle 2; later flag changes must be ignored.
      if (c == 2) flags = ~fl;
      check($sformatf("%s:cyc%0d", name, c), snap(), exp);
      if (c < last) begin @(posedge clk); #1; end
    end
    check($sformatf("%s:rsp", name), {61'h0, rsp_executed, rsp_borrow, rsp_zero},
          {61'h0, e_exec, e_borrow, e_zero});
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check($sformatf("%s:hold%0d", name, h), snap(), mk(1'b0, '0, 1'b0, '0, '0, 1'b1, 1'b0));
      check($sformatf("%s:holdrsp%0d", name, h), {61'h0, rsp_executed, rsp_borrow, rsp_zero},
            {61'h0, e_exec, e_borrow, e_zero});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check($sformatf("%s:done", name), snap(), mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1));
    if (e_exec) model_rf[r.dest] = e_data;
  endtask

  typedef struct {
    string       name;
    logic        a_is_addr;
    logic [31:0] a_val;
    logic        b_is_addr;
    logic [31:0] b_val;
    logic [7:0]  dest;
    logic        en;
    logic [LCISC_FLAG_IDX_W-1:0] idx;
    logic        pol;
    logic [7:0]  fl;
    int unsigned hold;
    logic        e_exec;
    logic [31:0] e_data;
    logic        e_borrow;
    logic        e_zero;
  } vec_t;

  vec_t vecs [7];

  initial begin : main
    subtract_req_t r;
    logic ex, bo, ze;
    logic [31:0] d;
    logic [NF-1:0] fl;

    for (int i = 0; i < 256; i++) model_rf[i] = init_val(i);

    vecs[0] = '{"imm_sub",    1'b0, 32'd10,          1'b0, 32'd3, 8'd5,  1'b0, 3'd0, 1'b0, 8'h00, 0, 1'b1, 32'd7,          1'b0, 1'b0};
    vecs[1] = '{"addr_sub",   1'b1, 32'd1,           1'b1, 32'd2, 8'd1,  1'b0, 3'd0, 1'b0, 8'h00, 1, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[2] = '{"cond_skip",  1'b0, 32'd100,         1'b0, 32'd1, 8'd9,  1'b1, 3'd3, 1'b1, 8'hF7, 0, 1'b0, 32'd0,          1'b0, 1'b0};
    vecs[3] = '{"equal_hold", 1'b0, 32'h1234_5678,   1'b1, 32'd7, 8'd9,  1'b0, 3'd0, 1'b0, 8'h00, 4, 1'b1, 32'd0,          1'b0, 1'b1};
    vecs[4] = '{"pol0_wrap",  1'b0, 32'd0,           1'b0, 32'd1, 8'd20, 1'b1, 3'd5, 1'b0, 8'hDF, 1, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0};
    vecs[5] = '{"upper_bits", 1'b1, 32'hABCD_0102,   1'b0, 32'd1, 8'd30, 1'b1, 3'd0, 1'b1, 8'h01, 0, 1'b1, 32'd0,          1'b0, 1'b1};
    vecs[6] = '{"skip_pol0",  1'b1, 32'd3,           1'b0, 32'd4, 8'd11, 1'b1, 3'd7, 1'b0, 8'h80, 2, 1'b0, 32'd0,          1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", snap(), mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0));
    check("reset_rsp", {61'h0, rsp_executed, rsp_borrow, rsp_zero}, 64'd0);
    rf_load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release", snap(), mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1));

    foreach (vecs[i]) begin
      r.op1  = '{vecs[i].a_is_addr, vecs[i].a_val};
      r.op2  = '{vecs[i].b_is_addr, vecs[i].b_val};
      r.dest = vecs[i].dest;
      r.cond = '{vecs[i].en, vecs[i].idx, vecs[i].pol};
      run_instr(vecs[i].name, r, vecs[i].fl, vecs[i].hold, vecs[i].e_exec,
                vecs[i].e_data, vecs[i].e_borrow, vecs[i].e_zero);
    end

    // Reset pulse while in RD_B: no write, no response, then normal operation.
    r.op1  = '{1'b1, 32'd3};
    r.op2  = '{1'b1, 32'd4};
    r.dest = 8'd6;
    r.cond = '{1'b0, 3'd0, 1'b0};
    @(negedge clk);
    in_valid = 1'b1; in_req = r;
    @(posedge clk); #1;
    in_valid = 1'b0; in_req = '0;
    check("rst_rda", snap(), mk(1'b1, 8'd3, 1'b0, '0, '0, 1'b0, 1'b0));
    @(posedge clk); #1;
    check("rst_rdb", snap(), mk(1'b1, 8'd4, 1'b0, '0, '0, 1'b0, 1'b0));
    #2 rst_n = 1'b0;
    #1 check("rst_async", snap(), mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      check($sformatf("rst_idle%0d", c), snap(), mk(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1));
    end
    check("rst_no_write", 64'(rf_mem[6]), 64'(model_rf[6]));
    r.op1  = '{1'b1, 32'd6};
    r.op2  = '{1'b0, 32'd0};
    r.dest = 8'd12;
    model_eval(r, '0, ex, d, bo, ze);
    run_instr("after_rst", r, '0, 0, ex, d, bo, ze);

    // Randomized requests.
    for (int n = 0; n < 40; n++) begin
      r.op1.is_addr = 1'($urandom_range(0, 1));
      r.op1.val     = $urandom();
      if (r.op1.is_addr) r.op1.val[7:0] = 8'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r.op1.val = 32'($urandom_range(0, 3));
      r.op2.is_addr = 1'($urandom_range(0, 1));
      r.op2.val     = $urandom();
      if (r.op2.is_addr) r.op2.val[7:0] = 8'($urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0) r.op2.val = 32'($urandom_range(0, 3));
      r.dest = 8'($urandom_range(0, 15));
      r.cond = '{1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
      fl     = NF'($urandom());
      model_eval(r, fl, ex, d, bo, ze);
      run_instr($sformatf("rand%0d", n), r, fl, 32'($urandom_range(0, 2)), ex, d, bo, ze);
    end

    for (int i = 0; i < 16; i++)
      check($sformatf("rf_final%0d", i), 64'(rf_mem[i]), 64'(model_rf[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/subtract_exec_unit.md
# subtract_exec_unit

Sequential hardware executor for lcisc subtract instructions. Accepts one packed subtract request (two immediate-or-address operands, destination address, single-flag condition) over a valid/ready handshake, resolves address operands through one read port of the u32 environment register file, and writes `A - B` (mod 2^32) to the destination when the condition holds. It returns a per-instruction response with executed/borrow/zero status. It sits between the instruction issue stage and the environment register file.

## Interface
- `ADDR_W`, default `LCISC_ADDR_W` (8): register-file address width.
- `NUM_FLAGS`, default `LCISC_NUM_FLAGS` (8): width of the flag vector.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `in_req` in `$bits(subtract_req_t)`: packed request `{op1, op2, dest, cond}`.
- `flags` in `NUM_FLAGS`: environment condition flags.
- `rf_rd_en` out 1: register read strobe.
- `rf_rd_addr` out `ADDR_W`: read address.
- `rf_rd_data` in 32: read data, valid the cycle after `rf_rd_en`.
- `rf_wr_en` out 1: register write strobe, one cycle.
- `rf_wr_addr` out `ADDR_W`: write address.
- `rf_wr_data` out 32: write data.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_executed` out 1: condition passed and write performed.
- `rsp_borrow` out 1: unsigned `A < B`.
- `rsp_zero` out 1: `A == B`.

## Operation
- Operand `ia_u32_t = {is_addr, val[31:0]}`. If `is_addr` is 1, the operand is `regfile[val[ADDR_W-1:0]]`, with upper bits ignored. Otherwise the operand is the immediate `val`.
- Condition `cond_t = {en, idx[$clog2(NUM_FLAGS)-1:0], pol}`.
  - Pass if `en==0`.
  - Otherwise pass iff `flags[idx]==pol`.
  - `idx >= NUM_FLAGS` fails.
- FSM states: IDLE, RD_A, RD_B, WB, RSP.
  - IDLE: `in_ready=1`. On `in_valid`, register `in_req` and go to RD_A.
  - RD_A: sample `flags`, evaluate the condition, and latch the result.
    - If the condition fails, go to RSP with `executed=0`, `borrow=0`, `zero=0`. No reads and no write occur.
    - Otherwise assert `rf_rd_en` with op1's address if op1 `is_addr`, and go to RD_B.
  - RD_B: capture A (`rf_rd_data` if op1 `is_addr`, else the immediate). Assert `rf_rd_en` with op2's address if op2 `is_addr`. Go to WB.
  - WB: B = `rf_rd_data` or the immediate. Assert `rf_wr_en`, with `rf_wr_addr=dest` and `rf_wr_data=A-B` truncated to 32 bits. Register borrow and zero. Go to RSP.
  - RSP: `rsp_valid=1`, with all `rsp_*` fields held stable. On `rsp_ready`, go to IDLE.
- `in_ready` is low in every state except IDLE. There is no overlap between instructions.
- Arithmetic: 32-bit unsigned wrap. `borrow = A < B` unsigned.
- `dest` may equal an operand address. Both reads complete before the write, so old values are used.
- Outputs not being driven are 0: `rf_rd_addr`, `rf_wr_addr`, and `rf_wr_data` are 0 when their strobes are low.

## Timing
- Reset (`rst_n` low, asynchronous): state IDLE. All outputs 0 except `in_ready`, which is 1 once reset is released. Registered request cleared.
- Reset mid-operation: immediate return to IDLE. No write is issued after reset assertion, and any pending response is dropped.
- Latency is fixed and independent of immediate/address mix. With acceptance at edge T:
  - RD_A in cycle T+1.
  - Write (executed case) in cycle T+3.
  - `rsp_valid` first high in cycle T+4.
  - Failed condition: `rsp_valid` in cycle T+2.
- Minimum issue interval is 5 cycles (executed) or 3 cycles (skipped), with `rsp_ready` tied high.
- `flags` is sampled only in RD_A. Flag changes afterwards do not affect the instruction.
- `rsp_ready` held low: the unit stays in RSP indefinitely. `in_ready` stays 0 and no further RF traffic occurs.

## Structure
- Shared package `lcisc_subtract_pkg`:
  - `LCISC_ADDR_W`, `LCISC_NUM_FLAGS`.
  - Typedefs `ia_u32_t`, `cond_t`, `subtract_req_t` (packed, field order as above).
  - State enum `sub_state_e`.
- One natural sub-module, `lcisc_cond_check`: combinational pass/fail from `cond_t` and `flags`. It is reusable by other lcisc executors.
- All other logic lives in `subtract_exec_unit`.

## Test plan
- Both operands immediate, op1=10, op2=3, dest=5, `en=0`: write addr 5 data 7 at T+3. Response executed=1, borrow=0, zero=0. `rf_rd_en` never asserted.
- Both operands address, reg[1]=0, reg[2]=1, dest=1:
  - Reads addr 1 at T+1 and addr 2 at T+2.
  - Write addr 1 data 0xFFFFFFFF.
  - Response borrow=1.
- Condition `en=1`, idx=3, pol=1, with `flags[3]=0`: no read or write. `rsp_valid` at T+2 with executed=0.
- Equal operands 0x12345678 (immediate and address), `rsp_ready` low for 4 cycles: response held stable with zero=1. `in_ready` stays 0 until the handshake, then returns to 1.
- `rst_n` pulsed low during RD_B: no `rf_wr_en` ever asserted, `rsp_valid` stays 0, unit accepts a new request right after release.
